// File: rtl/reorder_queue_mc_if.sv
// reorder_queue_mc_if: allocation, response-write and retire-stream signals of reorder_queue_mc.
interface reorder_queue_mc_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64,
    parameter int CHANNELS = 4
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic init_done;
    logic alloc;
    logic [CH_W-1:0] alloc_ch;
    logic [TAG_W:0] alloc_tag;
    logic [CHANNELS-1:0] full;
    logic wr_en;
    logic [CH_W-1:0] wr_ch;
    logic [TAG_W:0] wr_tag;
    logic [WIDTH-1:0] wr_data;
    logic rd_valid;
    logic rd_ready;
    logic [CH_W-1:0] rd_ch;
    logic [WIDTH-1:0] rd_data;
    modport master (
        input init_done, alloc_tag, full, rd_valid, rd_ch, rd_data,
        output alloc, alloc_ch, wr_en, wr_ch, wr_tag, wr_data, rd_ready
    );
    modport slave (
        output init_done, alloc_tag, full, rd_valid, rd_ch, rd_data,
        input alloc, alloc_ch, wr_en, wr_ch, wr_tag, wr_data, rd_ready
    );
endinterface

// File: rtl/reorder_queue_mc.sv
// reorder_queue_mc: per-channel in-order retirement of out-of-order tagged responses, round-robin merged.
// Define REORDER_QUEUE_MC_CHECK_EN for simulation-only protocol checks (alloc on full, tag range, double write).
module reorder_queue_mc #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64,
    parameter int CHANNELS = 4
) (
    input logic clk,
    input logic rst,
    reorder_queue_mc_if.slave q
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN = 1'b1;

    logic [0:0] state;
    logic [TAG_W-1:0] cnt;
    logic [TAG_W:0] beg_p [CHANNELS];
    logic [TAG_W:0] end_p [CHANNELS];
    logic [DEPTH-1:0] occ [CHANNELS];
    logic [WIDTH-1:0] ram [CHANNELS][DEPTH];
    logic [CHANNELS-1:0] head_rdy;
    logic [CH_W-1:0] rr, gnt_ch, k;
    logic gnt, load;

    assign q.init_done = state == RUN;
    assign q.alloc_tag = end_p[q.alloc_ch];
    assign load = !q.rd_valid || q.rd_ready;

    // occ holds the lap phase of the last write, so a head is ready once its phase matches beg
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign q.full[c] = beg_p[c][TAG_W-1:0] == end_p[c][TAG_W-1:0] && beg_p[c][TAG_W] != end_p[c][TAG_W];
        assign head_rdy[c] = occ[c][beg_p[c][TAG_W-1:0]] == beg_p[c][TAG_W] && beg_p[c] != end_p[c];
    end

    // descending scan so the channel nearest the RR pointer wins
    always_comb begin
        gnt = 1'b0;
        gnt_ch = '0;
        k = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            k = CH_W'((int'(rr) + i) % CHANNELS);
            gnt = gnt | head_rdy[k];
            gnt_ch = head_rdy[k] ? k : gnt_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt <= '0;
            rr <= '0;
            q.rd_valid <= 1'b0;
            q.rd_ch <= '0;
            q.rd_data <= '0;
            for (int j = 0; j < CHANNELS; j++) begin
                beg_p[j] <= '0;
                end_p[j] <= '0;
            end
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == TAG_W'(DEPTH - 1)) state <= RUN;
        end else begin
            if (q.alloc && !q.full[q.alloc_ch]) end_p[q.alloc_ch] <= end_p[q.alloc_ch] + 1'b1;
            if (load) begin
                q.rd_valid <= gnt;
                if (gnt) begin
                    q.rd_ch <= gnt_ch;
                    q.rd_data <= ram[gnt_ch][beg_p[gnt_ch][TAG_W-1:0]];
                    beg_p[gnt_ch] <= beg_p[gnt_ch] + 1'b1;
                    rr <= CH_W'((int'(gnt_ch) + 1) % CHANNELS);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == INIT) begin
            for (int j = 0; j < CHANNELS; j++) occ[j][cnt] <= 1'b1;
        end else if (!rst && q.wr_en) begin
            ram[q.wr_ch][q.wr_tag[TAG_W-1:0]] <= q.wr_data;
            occ[q.wr_ch][q.wr_tag[TAG_W-1:0]] <= q.wr_tag[TAG_W];
        end
    end

`ifdef REORDER_QUEUE_MC_CHECK_EN
    logic [DEPTH-1:0] pend [CHANNELS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < CHANNELS; j++) pend[j] <= '0;
        end else if (state == RUN) begin
            if (q.alloc && q.full[q.alloc_ch]) begin
                $display("reorder_queue_mc error: alloc on full channel %0d", q.alloc_ch);
                $finish;
            end
            if (q.wr_en && (q.wr_tag - beg_p[q.wr_ch]) >= (end_p[q.wr_ch] - beg_p[q.wr_ch])) begin
                $display("reorder_queue_mc error: tag %0h outside window on channel %0d", q.wr_tag, q.wr_ch);
                $finish;
            end
            if (q.wr_en && pend[q.wr_ch][q.wr_tag[TAG_W-1:0]]) begin
                $display("reorder_queue_mc error: double write of tag %0h on channel %0d", q.wr_tag, q.wr_ch);
                $finish;
            end
            if (q.wr_en) pend[q.wr_ch][q.wr_tag[TAG_W-1:0]] <= 1'b1;
            if (load && gnt) pend[gnt_ch][beg_p[gnt_ch][TAG_W-1:0]] <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_reorder_queue_mc.sv
// tb_reorder_queue_mc: directed scenarios plus random traffic against a per-channel sequence scoreboard.
module tb_reorder_queue_mc;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CHANNELS = 2;
    localparam int TAGS = 2 * DEPTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reorder_queue_mc_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) q();
    reorder_queue_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (.clk(clk), .rst(rst), .q(q));

    int nchk = 0;
    int nerr = 0;
    int alloc_n [CHANNELS];
    int acc_n [CHANNELS];
    bit wflag [CHANNELS][TAGS];
    logic [WIDTH-1:0] mdat [CHANNELS][TAGS];
    int init_left = -1;
    bit hold = 1'b0;
    logic [WIDTH-1:0] pd;
    logic pc;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < CHANNELS; c++) begin
            alloc_n[c] = 0;
            acc_n[c] = 0;
            for (int t = 0; t < TAGS; t++) wflag[c][t] = 1'b0;
        end
    endtask

    // Apply the effect of the coming clock edge to the model, then advance to the next negedge.
    task automatic cyc();
        int c, t;
        #1;
        if (init_left >= 0) chk("init_done", 64'(q.init_done), 64'(init_left == 0));
        if (init_left > 0) chk("init_idle", 64'(q.rd_valid), 64'(0));
        if (rst) begin
            clear_model();
            init_left = DEPTH;
            hold = 1'b0;
        end else if (init_left > 0) begin
            init_left--;
        end else if (init_left == 0) begin
            if (hold) begin
                chk("hold_valid", 64'(q.rd_valid), 64'(1));
                chk("hold_data", 64'(q.rd_data), 64'(pd));
                chk("hold_ch", 64'(q.rd_ch), 64'(pc));
            end
            for (int j = 0; j < CHANNELS; j++)
                if (alloc_n[j] - acc_n[j] < DEPTH) chk("not_full", 64'(q.full[j]), 64'(0));
            if (q.alloc) begin
                c = int'(q.alloc_ch);
                chk("alloc_tag", 64'(q.alloc_tag), 64'(alloc_n[c] % TAGS));
                if (alloc_n[c] - acc_n[c] < DEPTH) alloc_n[c]++;
            end
            if (q.wr_en) begin
                c = int'(q.wr_ch);
                t = int'(q.wr_tag);
                wflag[c][t] = 1'b1;
                mdat[c][t] = q.wr_data;
            end
            if (q.rd_valid && q.rd_ready) begin
                c = int'(q.rd_ch);
                t = acc_n[c] % TAGS;
                chk("rd_written", 64'(wflag[c][t]), 64'(1));
                chk("rd_data", 64'(q.rd_data), 64'(mdat[c][t]));
                wflag[c][t] = 1'b0;
                acc_n[c]++;
            end
            hold = q.rd_valid && !q.rd_ready;
            pd = q.rd_data;
            pc = q.rd_ch;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_alloc(int c);
        q.alloc = 1'b1;
        q.alloc_ch = 1'(c);
        cyc();
        q.alloc = 1'b0;
    endtask

    task automatic wr(int c, int t, int d);
        q.wr_en = 1'b1;
        q.wr_ch = 1'(c);
        q.wr_tag = 4'(t);
        q.wr_data = 16'(d);
        cyc();
        q.wr_en = 1'b0;
    endtask

    task automatic wait_init();
        int n = 0;
        while (!q.init_done && n < 20) begin
            cyc();
            n++;
        end
        chk("init_cycles", 64'(n), 64'(DEPTH));
    endtask

    task automatic drain();
        int n = 0;
        bit busy = 1'b1;
        q.rd_ready = 1'b1;
        while (busy && n < 200) begin
            cyc();
            n++;
            busy = 1'b0;
            for (int c = 0; c < CHANNELS; c++) if (alloc_n[c] != acc_n[c]) busy = 1'b1;
        end
        chk("drain_done", 64'(busy), 64'(0));
    endtask

    task automatic write_all();
        int a, b;
        for (int c = 0; c < CHANNELS; c++) begin
            a = acc_n[c];
            b = alloc_n[c];
            for (int s = a; s < b; s++)
                if (!wflag[c][s % TAGS]) wr(c, s % TAGS, int'($urandom_range(0, 16'hffff)));
        end
    endtask

    initial begin
        int c, o, s;
        clear_model();
        rst = 1'b1;
        q.alloc = 1'b0;
        q.alloc_ch = '0;
        q.wr_en = 1'b0;
        q.wr_ch = '0;
        q.wr_tag = '0;
        q.wr_data = '0;
        q.rd_ready = 1'b0;
        cyc();
        rst = 1'b0;
        // reset and initialisation length
        chk("reset_init_done", 64'(q.init_done), 64'(0));
        chk("reset_valid", 64'(q.rd_valid), 64'(0));
        wait_init();
        chk("reset_full", 64'(q.full), 64'(0));
        chk("reset_tag", 64'(q.alloc_tag), 64'(0));
        // in-order retirement of out-of-order writes
        q.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) do_alloc(0);
        wr(0, 3, 3);
        chk("early_valid3", 64'(q.rd_valid), 64'(0));
        wr(0, 1, 1);
        chk("early_valid1", 64'(q.rd_valid), 64'(0));
        wr(0, 2, 2);
        chk("early_valid2", 64'(q.rd_valid), 64'(0));
        wr(0, 0, 0);
        chk("latency_n", 64'(q.rd_valid), 64'(0));
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("order_valid", 64'(q.rd_valid), 64'(1));
            chk("order_data", 64'(q.rd_data), 64'(i));
        end
        cyc();
        chk("order_empty", 64'(q.rd_valid), 64'(0));
        // full flag on ch1, dropped alloc, unblock by retire
        for (int i = 0; i < DEPTH; i++) do_alloc(1);
        chk("full1", 64'(q.full[1]), 64'(1));
        chk("full0", 64'(q.full[0]), 64'(0));
        do_alloc(1);
        q.alloc_ch = 1'b1;
        #1;
        chk("drop_tag", 64'(q.alloc_tag), 64'(8));
        chk("drop_full", 64'(q.full[1]), 64'(1));
        wr(1, 0, 16'h100);
        chk("full_before_retire", 64'(q.full[1]), 64'(1));
        cyc();
        chk("full_after_retire", 64'(q.full[1]), 64'(0));
        for (int t = 1; t < DEPTH; t++) wr(1, t, 16'h100 + t);
        drain();
        // round-robin interleave
        q.rd_ready = 1'b0;
        do_alloc(0);
        do_alloc(0);
        do_alloc(1);
        do_alloc(1);
        wr(0, 4, 16'h204);
        wr(0, 5, 16'h205);
        wr(1, 8, 16'h308);
        wr(1, 9, 16'h309);
        cyc();
        q.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_valid", 64'(q.rd_valid), 64'(1));
            chk("rr_ch", 64'(q.rd_ch), 64'(i % 2));
            cyc();
        end
        chk("rr_empty", 64'(q.rd_valid), 64'(0));
        // backpressure holds the output
        q.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_alloc(0);
        do_alloc(1);
        do_alloc(1);
        for (int t = 6; t < 9; t++) wr(0, t, 16'h200 + t);
        wr(1, 10, 16'h30a);
        wr(1, 11, 16'h30b);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(q.rd_valid), 64'(1));
            chk("bp_data", 64'(q.rd_data), 64'(16'h206));
            chk("bp_ch", 64'(q.rd_ch), 64'(0));
            cyc();
        end
        drain();
        // random traffic
        for (int it = 0; it < 1500; it++) begin
            q.rd_ready = $urandom_range(0, 3) != 0;
            c = int'($urandom_range(0, CHANNELS - 1));
            q.alloc = alloc_n[c] - acc_n[c] < DEPTH && $urandom_range(0, 1) == 1;
            q.alloc_ch = 1'(c);
            c = int'($urandom_range(0, CHANNELS - 1));
            o = alloc_n[c] - acc_n[c];
            s = acc_n[c] + (o > 0 ? int'($urandom_range(0, o - 1)) : 0);
            q.wr_en = o > 0 && !wflag[c][s % TAGS] && $urandom_range(0, 2) != 0;
            q.wr_ch = 1'(c);
            q.wr_tag = 4'(s % TAGS);
            q.wr_data = 16'($urandom_range(0, 16'hffff));
            cyc();
        end
        q.alloc = 1'b0;
        q.wr_en = 1'b0;
        q.rd_ready = 1'b1;
        write_all();
        drain();
        // reset mid-stream
        q.rd_ready = 1'b0;
        s = alloc_n[0];
        for (int i = 0; i < 3; i++) do_alloc(0);
        for (int i = 0; i < 3; i++) wr(0, (s + i) % TAGS, 16'h400 + i);
        cyc();
        chk("pre_rst_valid", 64'(q.rd_valid), 64'(1));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_valid", 64'(q.rd_valid), 64'(0));
        wait_init();
        chk("rst_full", 64'(q.full), 64'(0));
        q.alloc_ch = 1'b0;
        #1;
        chk("rst_tag0", 64'(q.alloc_tag), 64'(0));
        q.alloc_ch = 1'b1;
        #1;
        chk("rst_tag1", 64'(q.alloc_tag), 64'(0));
        q.rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("no_stale", 64'(q.rd_valid), 64'(0));
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
